// File: rtl/rom2ram_loader_if.sv
// Signal bundle between the boot-time ROM copier, the SPI config flash and the
// memory controller's rom2ram write port.
interface rom2ram_loader_if;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic [16:0] rom2ram_ram_address;
    logic        rom2ram_ram_wren;
    logic [7:0]  rom2ram_dataout;
    logic        active;
    logic        done;

    modport master (
        output spi_cs_n,
        output spi_sck,
        output spi_mosi,
        input  spi_miso,
        output rom2ram_ram_address,
        output rom2ram_ram_wren,
        output rom2ram_dataout,
        output active,
        output done
    );

    modport slave (
        input  spi_cs_n,
        input  spi_sck,
        input  spi_mosi,
        output spi_miso,
        input  rom2ram_ram_address,
        input  rom2ram_ram_wren,
        input  rom2ram_dataout,
        input  active,
        input  done
    );
endinterface

// File: rtl/rom2ram_loader.sv
// Boot-time copier: streams a ROM image out of SPI flash (mode 0, READ 0x03)
// and writes it byte by byte into SRAM through the memory controller.
module rom2ram_loader #(
    parameter logic [23:0] FLASH_BASE = 24'h080000,
    parameter int          BYTES      = 131072,
    parameter int          SCK_DIV    = 2,
    parameter int          WR_CYCLES  = 2
) (
    input  logic             clk28,
    input  logic             rst,
    rom2ram_loader_if.master bus
);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, RX, SETUP, WRITE, HOLD, FINISH, DONE
    } state_t;

    localparam logic [31:0] HEADER    = {8'h03, FLASH_BASE};
    localparam logic [15:0] DIV_LAST  = 16'(SCK_DIV - 1);
    localparam logic [15:0] WR_LAST   = 16'(WR_CYCLES - 1);
    localparam logic [16:0] ADDR_LAST = 17'(BYTES - 1);

    state_t      state_q;
    logic        csN_q;
    logic        sck_q;
    logic        wren_q;
    logic        active_q;
    logic        done_q;
    logic [16:0] addr_q;
    logic [7:0]  data_q;
    logic [7:0]  rxShift_q;
    logic [31:0] txShift_q;
    logic [5:0]  bitCnt_q;
    logic [15:0] divCnt_q;
    logic [15:0] wrCnt_q;

    logic sckTick;
    logic sckRise;
    logic sckFall;

    assign sckTick = (divCnt_q == DIV_LAST);
    assign sckRise = sckTick && !sck_q;
    assign sckFall = sckTick && sck_q;

    // MOSI is simply the top of the transmit shifter, so it only moves when the shifter does.
    assign bus.spi_cs_n            = csN_q;
    assign bus.spi_sck             = sck_q;
    assign bus.spi_mosi            = txShift_q[31];
    assign bus.rom2ram_ram_address = addr_q;
    assign bus.rom2ram_ram_wren    = wren_q;
    assign bus.rom2ram_dataout     = data_q;
    assign bus.active              = active_q;
    assign bus.done                = done_q;

    always_ff @(posedge clk28) begin
        if (rst) begin
            state_q   <= IDLE;
            csN_q     <= 1'b1;
            sck_q     <= 1'b0;
            wren_q    <= 1'b0;
            active_q  <= 1'b1;
            done_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= 8'hFF;
            rxShift_q <= '0;
            txShift_q <= '0;
            bitCnt_q  <= '0;
            divCnt_q  <= '0;
            wrCnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    csN_q     <= 1'b0;
                    txShift_q <= HEADER;
                    divCnt_q  <= '0;
                    bitCnt_q  <= '0;
                    state_q   <= CMD;
                end
                CMD, ADDR, RX: begin
                    if (sckTick) begin
                        divCnt_q <= '0;
                        sck_q    <= ~sck_q;
                    end else begin
                        divCnt_q <= divCnt_q + 16'd1;
                    end
                    if (sckRise) begin
                        bitCnt_q  <= bitCnt_q + 6'd1;
                        rxShift_q <= {rxShift_q[6:0], bus.spi_miso};
                    end
                    // Phase changes happen on the falling edge so the next MOSI bit is set up half a period early.
                    if (sckFall) begin
                        txShift_q <= {txShift_q[30:0], 1'b0};
                        if (state_q == CMD && bitCnt_q == 6'd8) begin
                            state_q <= ADDR;
                        end else if (state_q == ADDR && bitCnt_q == 6'd32) begin
                            state_q  <= RX;
                            bitCnt_q <= '0;
                        end else if (state_q == RX && bitCnt_q == 6'd8) begin
                            state_q  <= SETUP;
                            data_q   <= rxShift_q;
                            bitCnt_q <= '0;
                        end
                    end
                end
                SETUP: begin
                    wren_q  <= 1'b1;
                    wrCnt_q <= '0;
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (wrCnt_q == WR_LAST) begin
                        wren_q  <= 1'b0;
                        state_q <= HOLD;
                    end else begin
                        wrCnt_q <= wrCnt_q + 16'd1;
                    end
                end
                HOLD: begin
                    // The address doubles as the byte counter and never steps past the last byte.
                    if (addr_q == ADDR_LAST) begin
                        csN_q     <= 1'b1;
                        sck_q     <= 1'b0;
                        txShift_q <= '0;
                        state_q   <= FINISH;
                    end else begin
                        addr_q   <= addr_q + 17'd1;
                        divCnt_q <= '0;
                        state_q  <= RX;
                    end
                end
                FINISH: begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
